// File: rtl/icache_pkg.sv
// Shared types, geometry and address-slicing helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int SETS       = 16;
    localparam int LINE_WORDS = 4;
    localparam int INDEX_W    = $clog2(SETS);
    localparam int OFFSET_W   = $clog2(LINE_WORDS);
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_DONE
    } state_t;

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data flop storage: async read port, per-word fill port, tag+valid write and global clear.
module icache_array
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                fill_en,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [OFFSET_W-1:0] fill_offset,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic                tag_wr_en,
    input  logic [INDEX_W-1:0]  tag_wr_index,
    input  logic [TAG_W-1:0]    tag_wr_tag,
    input  logic                set_valid,
    input  logic                clear
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [DATA_W-1:0] data [SETS][LINE_WORDS];

    // Clear wins over a same-cycle install so an invalidate is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (tag_wr_en && set_valid) begin
            valid[tag_wr_index] <= 1'b1;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone gate its use.
    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tags[tag_wr_index] <= tag_wr_tag;
        end
        if (fill_en) begin
            data[fill_index][fill_offset] <= fill_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index][rd_offset];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: hit compare, line-fill FSM and miss-address latch.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd_en,
    output logic [DATA_W-1:0] cpu_instr,
    output logic              cpu_valid,
    output logic              cpu_stall,
    input  logic              inval,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   miss_addr;
    logic [OFFSET_W-1:0] cnt;
    logic                inval_flag;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;
    logic                hit;
    logic                start_miss;
    logic                fill_en;
    logic                last_beat;

    icache_array u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_index     (addr_index(cpu_addr)),
        .rd_offset    (addr_offset(cpu_addr)),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .fill_en      (fill_en),
        .fill_index   (addr_index(miss_addr)),
        .fill_offset  (cnt),
        .fill_data    (mem_rdata),
        .tag_wr_en    (state == ST_DONE),
        .tag_wr_index (addr_index(miss_addr)),
        .tag_wr_tag   (addr_tag(miss_addr)),
        .set_valid    (!inval_flag),
        .clear        (inval)
    );

    assign hit        = rd_valid && (rd_tag == addr_tag(cpu_addr));
    assign cpu_valid  = cpu_rd_en && (state == ST_IDLE) && hit;
    assign cpu_stall  = cpu_rd_en && !cpu_valid;
    assign cpu_instr  = cpu_valid ? rd_data : '0;
    assign start_miss = (state == ST_IDLE) && cpu_rd_en && !hit;
    assign fill_en    = (state == ST_FILL) && mem_rvalid;
    assign last_beat  = (cnt == OFFSET_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_miss)           state_next = ST_REQ;
            ST_REQ:  if (mem_ack)              state_next = ST_FILL;
            ST_FILL: if (fill_en && last_beat) state_next = ST_DONE;
            ST_DONE:                           state_next = ST_IDLE;
            default:                           state_next = ST_IDLE;
        endcase
    end

    // The fill index/tag come only from miss_addr, so fetch may wander during a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_addr  <= '0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
            cnt        <= '0;
            inval_flag <= 1'b0;
        end else begin
            if (start_miss) begin
                miss_addr <= cpu_addr;
                mem_addr  <= line_base(cpu_addr);
                mem_req   <= 1'b1;
            end else if ((state == ST_REQ) && mem_ack) begin
                mem_req <= 1'b0;
            end
            if (fill_en) begin
                cnt <= cnt + OFFSET_W'(1);
            end
            if (state == ST_DONE) begin
                inval_flag <= 1'b0;
            end else if (inval && (state != ST_IDLE)) begin
                inval_flag <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (cpu_valid && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (start_miss && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl with a simple ack-in-REQ, back-to-back-beat memory.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic        cpu_rd_en = 1'b0;
    logic [15:0] cpu_instr;
    logic        cpu_valid;
    logic        cpu_stall;
    logic        inval = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    icache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_addr   (cpu_addr),
        .cpu_rd_en  (cpu_rd_en),
        .cpu_instr  (cpu_instr),
        .cpu_valid  (cpu_valid),
        .cpu_stall  (cpu_stall),
        .inval      (inval),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Fetch addr until a hit or max_cyc stall cycles; memory acks in REQ and streams base+0..3.
    // Entered and left at posedge+1.
    task automatic run_miss(input logic [15:0] addr, input logic [15:0] base, input int max_cyc,
                            input int inval_beat, output int stalls, output logic got_valid,
                            output logic [15:0] instr, output logic [15:0] req_addr);
        int   beat;
        logic acked;
        logic rv;
        beat = 0; acked = 1'b0; stalls = 0; got_valid = 1'b0; instr = '0; req_addr = '0;
        cpu_addr = addr;
        cpu_rd_en = 1'b1;
        while (stalls < max_cyc) begin
            @(negedge clk);
            if (cpu_valid) begin
                got_valid = 1'b1;
                instr = cpu_instr;
                break;
            end
            stalls++;
            if (mem_req) req_addr = mem_addr;
            rv = acked && (beat < 4);
            mem_ack = mem_req;
            mem_rvalid = rv;
            mem_rdata = rv ? base + 16'(beat) : 16'hDEAD;
            inval = rv && (beat == inval_beat);
            @(posedge clk); #1;
            if (mem_ack) acked = 1'b1;
            if (rv) beat++;
            mem_ack = 1'b0; mem_rvalid = 1'b0; inval = 1'b0;
        end
        if (got_valid) begin
            @(posedge clk); #1;
        end
        cpu_rd_en = 1'b0;
    endtask

    task automatic expect_miss(input string name, input logic [15:0] addr, input logic [15:0] base,
                               input logic [15:0] exp_req, input logic [15:0] exp_instr);
        int          stalls;
        logic        got;
        logic [15:0] instr;
        logic [15:0] req;
        run_miss(addr, base, 12, -1, stalls, got, instr, req);
        checks++;
        if (stalls !== 7) begin
            failures++; $display("FAIL %s_stalls: got %0d want 7", name, stalls);
        end
        checks++;
        if (req !== exp_req) begin
            failures++; $display("FAIL %s_mem_addr: got %h want %h", name, req, exp_req);
        end
        checks++;
        if (got !== 1'b1 || instr !== exp_instr) begin
            failures++; $display("FAIL %s_instr: valid=%b got %h want %h", name, got, instr, exp_instr);
        end
    endtask

    // One-cycle lookup probe (no fill started): sampled at negedge, rd_en dropped before the edge.
    task automatic probe(input string name, input logic [15:0] addr, input logic rd,
                         input logic exp_valid, input logic exp_stall, input logic [15:0] exp_instr);
        cpu_addr = addr;
        cpu_rd_en = rd;
        @(negedge clk);
        checks++;
        if (cpu_valid !== exp_valid || cpu_stall !== exp_stall || cpu_instr !== exp_instr) begin
            failures++;
            $display("FAIL %s: valid=%b stall=%b instr=%h want valid=%b stall=%b instr=%h",
                     name, cpu_valid, cpu_stall, cpu_instr, exp_valid, exp_stall, exp_instr);
        end
        if (!exp_valid) cpu_rd_en = 1'b0;
        @(posedge clk); #1;
        cpu_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_rd_en = 1'b1;
        cpu_addr = 16'h0005;
        #1;
        checks++;
        if (cpu_valid !== 1'b0 || cpu_instr !== 16'h0000 || cpu_stall !== 1'b1) begin
            failures++; $display("FAIL reset_cpu_rd: valid=%b instr=%h stall=%b want 0 0000 1",
                                 cpu_valid, cpu_instr, cpu_stall);
        end
        cpu_rd_en = 1'b0;
        #1;
        checks++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 16'h0000) begin
            failures++; $display("FAIL reset_idle: stall=%b mem_req=%b mem_addr=%h want 0 0 0000",
                                 cpu_stall, mem_req, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        expect_miss("cold", 16'h0005, 16'hA000, 16'h0004, 16'hA001);
    endtask

    task automatic test_hit_streak();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = 16'hFFFF;
            end
            probe($sformatf("hit_%0d", i), 16'h0004 + 16'(i), 1'b1, 1'b1, 1'b0, 16'hA000 + 16'(i));
            mem_rvalid = 1'b0;
        end
        probe("stray_rvalid_ignored", 16'h0004, 1'b1, 1'b1, 1'b0, 16'hA000);
        probe("no_fetch", 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_conflict();
        expect_miss("conflict_new", 16'h0044, 16'hB000, 16'h0044, 16'hB000);
        expect_miss("conflict_old", 16'h0004, 16'hA000, 16'h0004, 16'hA000);
    endtask

    task automatic test_inval_idle();
        cpu_addr = 16'h0004;
        cpu_rd_en = 1'b1;
        inval = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_valid !== 1'b1 || cpu_instr !== 16'hA000) begin
            failures++; $display("FAIL inval_idle_same_cycle: valid=%b instr=%h want 1 a000",
                                 cpu_valid, cpu_instr);
        end
        @(posedge clk); #1;
        inval = 1'b0;
        probe("inval_idle_after", 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0000);
    endtask

    task automatic test_inval_fill();
        int          stalls;
        logic        got;
        logic [15:0] instr;
        logic [15:0] req;
        expect_miss("refill", 16'h0004, 16'hA000, 16'h0004, 16'hA000);
        run_miss(16'h0004, 16'hC000, 7, -1, stalls, got, instr, req);
        checks++;
        if (got !== 1'b1 || instr !== 16'hA000) begin
            failures++; $display("FAIL inval_fill_prehit: valid=%b instr=%h want 1 a000", got, instr);
        end
        run_miss(16'h0014, 16'hC000, 7, 1, stalls, got, instr, req);
        checks++;
        if (got !== 1'b0 || stalls !== 7) begin
            failures++; $display("FAIL inval_fill_run: valid=%b stalls=%0d want 0 7", got, stalls);
        end
        probe("inval_fill_line_invalid", 16'h0014, 1'b1, 1'b0, 1'b1, 16'h0000);
        probe("inval_fill_other_cleared", 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0000);
        expect_miss("inval_fill_refetch", 16'h0016, 16'hC100, 16'h0014, 16'hC102);
    endtask

    task automatic test_wrap();
        expect_miss("wrap", 16'hFFFF, 16'hD000, 16'hFFFC, 16'hD003);
        probe("wrap_hit_first", 16'hFFFC, 1'b1, 1'b1, 1'b0, 16'hD000);
    endtask

    task automatic test_reset_mid_fill();
        int          stalls;
        logic        got;
        logic [15:0] instr;
        logic [15:0] req;
        run_miss(16'h0008, 16'hE000, 3, -1, stalls, got, instr, req);
        cpu_addr = 16'h0008;
        cpu_rd_en = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || cpu_valid !== 1'b0 || cpu_stall !== 1'b1) begin
            failures++; $display("FAIL reset_mid_fill: mem_req=%b valid=%b stall=%b want 0 0 1",
                                 mem_req, cpu_valid, cpu_stall);
        end
        cpu_rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        probe("reset_cleared_valid", 16'hFFFC, 1'b1, 1'b0, 1'b1, 16'h0000);
        expect_miss("reset_refetch", 16'h0008, 16'hE000, 16'h0008, 16'hE000);
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_miss("stats_miss", 16'h0005, 16'hA000, 16'h0004, 16'hA001);
        probe("stats_hit_a", 16'h0006, 1'b1, 1'b1, 1'b0, 16'hA002);
        probe("stats_hit_b", 16'h0007, 1'b1, 1'b1, 1'b0, 16'hA003);
        probe("stats_hit_c", 16'h0004, 1'b1, 1'b1, 1'b0, 16'hA000);
        @(negedge clk);
        checks++;
        if (miss_cnt !== 16'd1 || hit_cnt !== 16'd4) begin
            failures++; $display("FAIL stats_counts: miss=%0d hit=%0d want 1 4", miss_cnt, hit_cnt);
        end
        force dut.hit_cnt = 16'hFFFF;
        #1;
        release dut.hit_cnt;
        @(posedge clk); #1;
        probe("stats_sat_hit", 16'h0004, 1'b1, 1'b1, 1'b0, 16'hA000);
        @(negedge clk);
        checks++;
        if (hit_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL stats_saturate: hit=%h want ffff", hit_cnt);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_streak();
        test_conflict();
        test_inval_idle();
        test_inval_fill();
        test_wrap();
        test_reset_mid_fill();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
